// File: rtl/conv_loop_sequencer.sv
// Convolution loop-nest sequencer: walks m,p,q (outer) and c,r,s (inner) after start
// and issues one MAC descriptor per valid/ready transfer, followed by a one-cycle done pulse.
module conv_loop_sequencer #(
    parameter int DIM_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  dim_c,
    input  logic [DIM_W-1:0]  dim_h,
    input  logic [DIM_W-1:0]  dim_w,
    input  logic [DIM_W-1:0]  dim_r,
    input  logic [DIM_W-1:0]  dim_s,
    input  logic [DIM_W-1:0]  dim_m,
    input  logic [DIM_W-1:0]  dim_p,
    input  logic [DIM_W-1:0]  dim_q,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] wt_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] wt_addr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              acc_first,
    output logic              acc_last,
    output logic              busy,
    output logic              done
);

    localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

    // EMPTY gives a zero-sized layer the same two-cycle start-to-done turnaround as a one-op layer
    typedef enum logic [1:0] {IDLE, RUN, EMPTY, DONE} state_t;

    state_t            state;
    logic [DIM_W-1:0]  cnt_c, cnt_r, cnt_s, cnt_m, cnt_p, cnt_q;
    logic [DIM_W-1:0]  lat_c, lat_h, lat_w, lat_r, lat_s, lat_m, lat_p, lat_q;
    logic [ADDR_W-1:0] lat_in_base, lat_wt_base, lat_out_base;

    logic              wrap_s, wrap_r, wrap_c, wrap_q, wrap_p, wrap_m;
    logic              final_op, any_zero;
    logic [DIM_W-1:0]  nxt_c, nxt_r, nxt_s, nxt_m, nxt_p, nxt_q;
    logic [DIM_W-1:0]  sel_c, sel_h, sel_w, sel_r, sel_s, sel_p, sel_q;
    logic [ADDR_W-1:0] sel_in_base, sel_wt_base, sel_out_base;
    logic [ADDR_W-1:0] nxt_in_addr, nxt_wt_addr, nxt_out_addr;
    logic              nxt_first, nxt_last;

    // Next descriptor: the first one straight from the inputs in IDLE, else the successor of the current one
    always_comb begin
        wrap_s   = (cnt_s == lat_s - DIM_ONE);
        wrap_r   = (cnt_r == lat_r - DIM_ONE);
        wrap_c   = (cnt_c == lat_c - DIM_ONE);
        wrap_q   = (cnt_q == lat_q - DIM_ONE);
        wrap_p   = (cnt_p == lat_p - DIM_ONE);
        wrap_m   = (cnt_m == lat_m - DIM_ONE);
        final_op = wrap_s && wrap_r && wrap_c && wrap_q && wrap_p && wrap_m;
        any_zero = (dim_c == '0) || (dim_r == '0) || (dim_s == '0) ||
                   (dim_m == '0) || (dim_p == '0) || (dim_q == '0);

        sel_c        = lat_c;
        sel_h        = lat_h;
        sel_w        = lat_w;
        sel_r        = lat_r;
        sel_s        = lat_s;
        sel_p        = lat_p;
        sel_q        = lat_q;
        sel_in_base  = lat_in_base;
        sel_wt_base  = lat_wt_base;
        sel_out_base = lat_out_base;
        nxt_s = wrap_s ? '0 : cnt_s + DIM_ONE;
        nxt_r = !wrap_s ? cnt_r : (wrap_r ? '0 : cnt_r + DIM_ONE);
        nxt_c = !(wrap_s && wrap_r) ? cnt_c : (wrap_c ? '0 : cnt_c + DIM_ONE);
        nxt_q = !(wrap_s && wrap_r && wrap_c) ? cnt_q : (wrap_q ? '0 : cnt_q + DIM_ONE);
        nxt_p = !(wrap_s && wrap_r && wrap_c && wrap_q) ? cnt_p : (wrap_p ? '0 : cnt_p + DIM_ONE);
        nxt_m = !(wrap_s && wrap_r && wrap_c && wrap_q && wrap_p) ? cnt_m :
                (wrap_m ? '0 : cnt_m + DIM_ONE);

        if (state == IDLE) begin
            sel_c        = dim_c;
            sel_h        = dim_h;
            sel_w        = dim_w;
            sel_r        = dim_r;
            sel_s        = dim_s;
            sel_p        = dim_p;
            sel_q        = dim_q;
            sel_in_base  = in_base;
            sel_wt_base  = wt_base;
            sel_out_base = out_base;
            nxt_s = '0;
            nxt_r = '0;
            nxt_c = '0;
            nxt_q = '0;
            nxt_p = '0;
            nxt_m = '0;
        end

        nxt_in_addr  = sel_in_base +
                       (ADDR_W'(nxt_c) * ADDR_W'(sel_h) + ADDR_W'(nxt_p) + ADDR_W'(nxt_r)) * ADDR_W'(sel_w) +
                       ADDR_W'(nxt_q) + ADDR_W'(nxt_s);
        nxt_wt_addr  = sel_wt_base +
                       ((ADDR_W'(nxt_m) * ADDR_W'(sel_c) + ADDR_W'(nxt_c)) * ADDR_W'(sel_r) + ADDR_W'(nxt_r)) *
                       ADDR_W'(sel_s) + ADDR_W'(nxt_s);
        nxt_out_addr = sel_out_base +
                       (ADDR_W'(nxt_m) * ADDR_W'(sel_p) + ADDR_W'(nxt_p)) * ADDR_W'(sel_q) + ADDR_W'(nxt_q);
        nxt_first    = (nxt_c == '0) && (nxt_r == '0) && (nxt_s == '0);
        nxt_last     = (nxt_c == sel_c - DIM_ONE) && (nxt_r == sel_r - DIM_ONE) &&
                       (nxt_s == sel_s - DIM_ONE);
    end

    // Control FSM with registered descriptor fields; abort overrides every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_valid     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            in_addr      <= '0;
            wt_addr      <= '0;
            out_addr     <= '0;
            acc_first    <= 1'b0;
            acc_last     <= 1'b0;
            cnt_c        <= '0;
            cnt_r        <= '0;
            cnt_s        <= '0;
            cnt_m        <= '0;
            cnt_p        <= '0;
            cnt_q        <= '0;
            lat_c        <= '0;
            lat_h        <= '0;
            lat_w        <= '0;
            lat_r        <= '0;
            lat_s        <= '0;
            lat_m        <= '0;
            lat_p        <= '0;
            lat_q        <= '0;
            lat_in_base  <= '0;
            lat_wt_base  <= '0;
            lat_out_base <= '0;
        end else if (abort) begin
            state    <= IDLE;
            op_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        lat_c        <= dim_c;
                        lat_h        <= dim_h;
                        lat_w        <= dim_w;
                        lat_r        <= dim_r;
                        lat_s        <= dim_s;
                        lat_m        <= dim_m;
                        lat_p        <= dim_p;
                        lat_q        <= dim_q;
                        lat_in_base  <= in_base;
                        lat_wt_base  <= wt_base;
                        lat_out_base <= out_base;
                        cnt_c        <= '0;
                        cnt_r        <= '0;
                        cnt_s        <= '0;
                        cnt_m        <= '0;
                        cnt_p        <= '0;
                        cnt_q        <= '0;
                        if (any_zero) begin
                            state <= EMPTY;
                        end else begin
                            state     <= RUN;
                            op_valid  <= 1'b1;
                            busy      <= 1'b1;
                            in_addr   <= nxt_in_addr;
                            wt_addr   <= nxt_wt_addr;
                            out_addr  <= nxt_out_addr;
                            acc_first <= nxt_first;
                            acc_last  <= nxt_last;
                        end
                    end
                end
                RUN: begin
                    if (op_ready) begin
                        if (final_op) begin
                            state    <= DONE;
                            op_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            cnt_c     <= nxt_c;
                            cnt_r     <= nxt_r;
                            cnt_s     <= nxt_s;
                            cnt_m     <= nxt_m;
                            cnt_p     <= nxt_p;
                            cnt_q     <= nxt_q;
                            in_addr   <= nxt_in_addr;
                            wt_addr   <= nxt_wt_addr;
                            out_addr  <= nxt_out_addr;
                            acc_first <= nxt_first;
                            acc_last  <= nxt_last;
                        end
                    end
                end
                EMPTY: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Testbench for conv_loop_sequencer: fixed vector tables, hand-built corner sequences and
// random layers checked against a loop-nest reference model.
module tb_conv_loop_sequencer;

    typedef struct {
        logic [7:0]  c, h, w, r, s, m, p, q;
        logic [15:0] ib, wb, ob;
    } cfg_t;

    typedef struct {
        logic        ready;
        logic [15:0] ia, wa, oa;
        logic        f, l;
    } vec_t;

    typedef struct packed {
        logic [15:0] ia, wa, oa;
        logic        f, l;
    } desc_t;

    logic        clk, rst_n, start, abort, op_ready;
    logic [7:0]  dim_c, dim_h, dim_w, dim_r, dim_s, dim_m, dim_p, dim_q;
    logic [15:0] in_base, wt_base, out_base;
    logic        op_valid, acc_first, acc_last, busy, done;
    logic [15:0] in_addr, wt_addr, out_addr;

    int    checks = 0;
    int    failures = 0;
    vec_t  tbl[17];
    desc_t expQ[$];

    conv_loop_sequencer #(.DIM_W(8), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dim_c(dim_c), .dim_h(dim_h), .dim_w(dim_w), .dim_r(dim_r),
        .dim_s(dim_s), .dim_m(dim_m), .dim_p(dim_p), .dim_q(dim_q),
        .in_base(in_base), .wt_base(wt_base), .out_base(out_base),
        .op_valid(op_valid), .op_ready(op_ready),
        .in_addr(in_addr), .wt_addr(wt_addr), .out_addr(out_addr),
        .acc_first(acc_first), .acc_last(acc_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input cfg_t cfg);
        dim_c = cfg.c; dim_h = cfg.h; dim_w = cfg.w; dim_r = cfg.r;
        dim_s = cfg.s; dim_m = cfg.m; dim_p = cfg.p; dim_q = cfg.q;
        in_base = cfg.ib; wt_base = cfg.wb; out_base = cfg.ob;
    endtask

    // Reference: the plain six-deep loop nest with the address formulas evaluated directly
    task automatic buildModel(input cfg_t cfg);
        desc_t d;
        int C, H, W, R, S, M, P, Q;
        C = cfg.c; H = cfg.h; W = cfg.w; R = cfg.r; S = cfg.s; M = cfg.m; P = cfg.p; Q = cfg.q;
        expQ.delete();
        for (int m = 0; m < M; m++)
            for (int p = 0; p < P; p++)
                for (int q = 0; q < Q; q++)
                    for (int c = 0; c < C; c++)
                        for (int r = 0; r < R; r++)
                            for (int s = 0; s < S; s++) begin
                                d.ia = 16'(int'(cfg.ib) + (c * H + p + r) * W + q + s);
                                d.wa = 16'(int'(cfg.wb) + ((m * C + c) * R + r) * S + s);
                                d.oa = 16'(int'(cfg.ob) + (m * P + p) * Q + q);
                                d.f  = (c == 0) && (r == 0) && (s == 0);
                                d.l  = (c == C - 1) && (r == R - 1) && (s == S - 1);
                                expQ.push_back(d);
                            end
    endtask

    task automatic runTable(input cfg_t cfg, input int lo, input int n, input string tag);
        vec_t v;
        @(negedge clk);
        applyStimulus(cfg);
        start = 1'b1;
        op_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            v = tbl[lo + k];
            checkOutput($sformatf("%s op_valid #%0d", tag, k), op_valid, 1);
            checkOutput($sformatf("%s in_addr #%0d", tag, k), in_addr, v.ia);
            checkOutput($sformatf("%s wt_addr #%0d", tag, k), wt_addr, v.wa);
            checkOutput($sformatf("%s out_addr #%0d", tag, k), out_addr, v.oa);
            checkOutput($sformatf("%s acc_first #%0d", tag, k), acc_first, v.f);
            checkOutput($sformatf("%s acc_last #%0d", tag, k), acc_last, v.l);
            op_ready = v.ready;
            @(negedge clk);
        end
        checkOutput({tag, " done pulse"}, done, 1);
        checkOutput({tag, " valid at done"}, op_valid, 0);
        @(negedge clk);
        checkOutput({tag, " done cleared"}, done, 0);
    endtask

    // Random op_ready, spurious start pulses and scrambled config while the layer runs
    task automatic runLayer(input cfg_t cfg, input int readyPct, input string tag);
        int budget, limit, idx;
        desc_t d;
        buildModel(cfg);
        limit = 20 * expQ.size() + 50;
        @(negedge clk);
        applyStimulus(cfg);
        start = 1'b1;
        op_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (expQ.size() == 0) begin
            checkOutput({tag, " empty valid"}, op_valid, 0);
            checkOutput({tag, " empty busy"}, busy, 0);
            checkOutput({tag, " empty early done"}, done, 0);
            @(negedge clk);
        end else begin
            budget = 0;
            idx = 0;
            while (expQ.size() > 0 && budget < limit) begin
                d = expQ[0];
                checkOutput($sformatf("%s op_valid #%0d", tag, idx), op_valid, 1);
                checkOutput($sformatf("%s busy #%0d", tag, idx), busy, 1);
                checkOutput($sformatf("%s done early #%0d", tag, idx), done, 0);
                checkOutput($sformatf("%s in_addr #%0d", tag, idx), in_addr, d.ia);
                checkOutput($sformatf("%s wt_addr #%0d", tag, idx), wt_addr, d.wa);
                checkOutput($sformatf("%s out_addr #%0d", tag, idx), out_addr, d.oa);
                checkOutput($sformatf("%s flags #%0d", tag, idx), {acc_first, acc_last}, {d.f, d.l});
                op_ready = ($urandom_range(99) < readyPct);
                start = ($urandom_range(3) == 0);
                dim_c = 8'($urandom); dim_r = 8'($urandom); dim_s = 8'($urandom);
                dim_m = 8'($urandom); dim_h = 8'($urandom); dim_w = 8'($urandom);
                in_base = 16'($urandom);
                if (op_ready) begin
                    void'(expQ.pop_front());
                    idx++;
                end
                budget++;
                @(negedge clk);
            end
            checkOutput({tag, " descriptors left"}, expQ.size(), 0);
            op_ready = 1'b0;
        end
        start = 1'($urandom_range(1));
        checkOutput({tag, " done pulse"}, done, 1);
        checkOutput({tag, " valid at done"}, op_valid, 0);
        checkOutput({tag, " busy at done"}, busy, 0);
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, " done cleared"}, done, 0);
        checkOutput({tag, " no restart from DONE"}, op_valid, 0);
    endtask

    initial begin
        cfg_t minCfg, smallCfg, cfg;
        tbl[0]  = '{1'b1, 16'h10, 16'h20, 16'h30, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 16'd1, 16'd1, 16'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 16'd3, 16'd2, 16'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 16'd4, 16'd3, 16'd0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 16'd1, 16'd0, 16'd1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 16'd2, 16'd1, 16'd1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 16'd4, 16'd2, 16'd1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 16'd5, 16'd3, 16'd1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 16'd3, 16'd0, 16'd2, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 16'd4, 16'd1, 16'd2, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 16'd6, 16'd2, 16'd2, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 16'd7, 16'd3, 16'd2, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 16'd4, 16'd0, 16'd3, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 16'd5, 16'd1, 16'd3, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 16'd7, 16'd2, 16'd3, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 16'd8, 16'd3, 16'd3, 1'b0, 1'b1};
        minCfg   = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 16'h10, 16'h20, 16'h30};
        smallCfg = '{8'd1, 8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd2, 8'd2, 16'h0, 16'h0, 16'h0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_ready = 1'b0;
        applyStimulus(smallCfg);
        #3;
        checkOutput("reset op_valid", op_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset addrs", {in_addr, wt_addr}, 0);
        checkOutput("reset out_addr/flags", {out_addr, acc_first, acc_last}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        runTable(minCfg, 0, 1, "minimal");
        runTable(smallCfg, 1, 16, "small");
        runLayer(smallCfg, 50, "backpressure");
        cfg = smallCfg; cfg.m = 8'd0;
        runLayer(cfg, 100, "zero_m");
        cfg = smallCfg; cfg.c = 8'd0;
        runLayer(cfg, 100, "zero_c");

        // Abort while descriptor 5 is on offer, then a clean restart
        @(negedge clk);
        applyStimulus(smallCfg);
        start = 1'b1; op_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort target in_addr", in_addr, 16'd1);
        checkOutput("abort target out_addr", out_addr, 16'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        op_ready = 1'b0;
        checkOutput("abort op_valid", op_valid, 0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort done", done, 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("post-abort done", done, 0);
            checkOutput("post-abort valid", op_valid, 0);
        end
        runTable(smallCfg, 1, 16, "restart");

        @(negedge clk);
        applyStimulus(smallCfg);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checkOutput("start+abort valid", op_valid, 0);
        checkOutput("start+abort busy", busy, 0);
        @(negedge clk);
        checkOutput("start+abort done", done, 0);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        applyStimulus(smallCfg);
        start = 1'b1; op_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre-reset in_addr", in_addr, 16'd4);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset valid/busy/done", {op_valid, busy, done}, 0);
        checkOutput("async reset addrs", {in_addr, wt_addr}, 0);
        checkOutput("async reset out/flags", {out_addr, acc_first, acc_last}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op_ready = 1'b0;
        @(negedge clk);
        checkOutput("after reset valid", op_valid, 0);
        checkOutput("after reset done", done, 0);

        for (int i = 0; i < 8; i++) begin
            cfg.c  = 8'($urandom_range(3, 1));
            cfg.r  = 8'($urandom_range(3, 1));
            cfg.s  = 8'($urandom_range(3, 1));
            cfg.m  = 8'($urandom_range(2, 1));
            cfg.p  = 8'($urandom_range(2, 1));
            cfg.q  = 8'($urandom_range(2, 1));
            cfg.h  = 8'($urandom_range(6, 1));
            cfg.w  = 8'($urandom_range(6, 1));
            cfg.ib = 16'($urandom);
            cfg.wb = 16'($urandom);
            cfg.ob = 16'($urandom);
            runLayer(cfg, int'($urandom_range(100, 30)), $sformatf("random%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
